// File: rtl/uart_spec_fifo.sv
// Receive FIFO with speculative write: an entry is stored pending and only becomes
// readable on commit. Optional macro UART_SPEC_FIFO_PARITY_DROP_EN turns commits of parity-flagged entries into rollbacks.
module uart_spec_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK288MHZ,
  input  logic          reset,
  input  logic [8:0]    dataIn,
  input  logic          writeEn,
  input  logic          commitWrite,
  input  logic          rollbackWrite,
  input  logic          readEn,
  output logic [8:0]    dataOut,
  output logic          rdValid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DROP} state_t;

  state_t      state_reg, state_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] spec_ptr_reg, spec_ptr_next;
  logic        overflow_next;
  logic        mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW:0] committed, occupancy, spec_last;
  logic        pop, do_rollback, do_commit, ctl_any;
  logic [8:0]  mem [DEPTH];
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
  logic        pend_par_reg, pend_par_next;
`endif

  assign committed   = wr_ptr_reg - rd_ptr_reg;
  assign occupancy   = spec_ptr_reg - rd_ptr_reg;
  assign spec_last   = spec_ptr_reg - PTR_ONE;
  assign pop         = readEn && (committed != '0);
  assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

  // Rollback outranks commit; any commit/rollback masks a same-cycle write.
  assign do_rollback = rollbackWrite;
  assign do_commit   = commitWrite && !rollbackWrite;
  assign ctl_any     = commitWrite || rollbackWrite;

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    spec_ptr_next = spec_ptr_reg;
    overflow_next = overflow;
    mem_we        = 1'b0;
    mem_waddr     = spec_ptr_reg[AW-1:0];
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
    pend_par_next = pend_par_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (writeEn && !ctl_any) begin
          if (occupancy != DEPTH_P) begin
            mem_we        = 1'b1;
            spec_ptr_next = spec_ptr_reg + PTR_ONE;
            state_next    = S_PEND;
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
            pend_par_next = dataIn[8];
`endif
          end else begin
            state_next = S_DROP;
          end
        end
      end
      S_PEND: begin
        if (do_rollback) begin
          spec_ptr_next = wr_ptr_reg;
          state_next    = S_IDLE;
        end else if (do_commit) begin
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
          if (pend_par_reg) spec_ptr_next = wr_ptr_reg;
          else              wr_ptr_next   = spec_ptr_reg;
`else
          wr_ptr_next = spec_ptr_reg;
`endif
          state_next = S_IDLE;
        end else if (writeEn) begin
          // Re-delivery of the same byte replaces the pending slot in place.
          mem_we    = 1'b1;
          mem_waddr = spec_last[AW-1:0];
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
          pend_par_next = dataIn[8];
`endif
        end
      end
      S_DROP: begin
        if (do_rollback) begin
          state_next = S_IDLE;
        end else if (do_commit) begin
          overflow_next = 1'b1;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK288MHZ) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      spec_ptr_reg <= '0;
      dataOut      <= '0;
      rdValid      <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      count        <= '0;
      overflow     <= 1'b0;
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
      pend_par_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      spec_ptr_reg <= spec_ptr_next;
      rdValid      <= pop;
      if (pop) dataOut <= mem[rd_ptr_reg[AW-1:0]];
      count        <= wr_ptr_next - rd_ptr_next;
      empty        <= (wr_ptr_next == rd_ptr_next);
      full         <= ((spec_ptr_next - rd_ptr_next) == DEPTH_P);
      overflow     <= overflow_next;
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
      pend_par_reg <= pend_par_next;
`endif
    end
  end

  always_ff @(posedge CLK288MHZ) begin
    if (mem_we && reset) mem[mem_waddr] <= dataIn;
  end

endmodule

// File: tb/tb_uart_spec_fifo.sv
// Directed self-checking bench for uart_spec_fifo (default and parity-drop builds).
module tb_uart_spec_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] dataIn;
  logic       writeEn, commitWrite, rollbackWrite, readEn;
  logic [8:0] dataOut;
  logic       rdValid, empty, full, overflow;
  logic [4:0] count;
  int nvec = 0;
  int nerr = 0;

  uart_spec_fifo #(.DEPTH(16), .AW(4)) dut (
    .CLK288MHZ(clk), .reset(reset), .dataIn(dataIn), .writeEn(writeEn),
    .commitWrite(commitWrite), .rollbackWrite(rollbackWrite), .readEn(readEn),
    .dataOut(dataOut), .rdValid(rdValid), .empty(empty), .full(full),
    .count(count), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
  endtask

  task automatic wr(input logic [8:0] d);
    writeEn = 1'b1; dataIn = d; tick(); writeEn = 1'b0;
  endtask

  task automatic cm();
    commitWrite = 1'b1; tick(); commitWrite = 1'b0;
  endtask

  task automatic rb();
    rollbackWrite = 1'b1; tick(); rollbackWrite = 1'b0;
  endtask

  task automatic rd();
    readEn = 1'b1; tick(); readEn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({dataOut, rdValid, empty, full, count, overflow} !== {9'h000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_state: dataOut=%h rdValid=%b empty=%b full=%b count=%0d overflow=%b required 000 0 1 0 0 0",
               dataOut, rdValid, empty, full, count, overflow);
    end
  endtask

  task automatic test_commit_read();
    wr(9'h041); tick(); cm();
    nvec++;
    if (count !== 5'd1 || empty !== 1'b0) begin
      nerr++; $display("FAIL commit_count: count=%0d empty=%b required 1 0", count, empty);
    end
    rd();
    nvec++;
    if (rdValid !== 1'b1 || dataOut !== 9'h041 || count !== 5'd0 || empty !== 1'b1) begin
      nerr++; $display("FAIL commit_read: rdValid=%b dataOut=%h count=%0d empty=%b required 1 041 0 1",
                       rdValid, dataOut, count, empty);
    end
    tick();
    nvec++;
    if (rdValid !== 1'b0) begin
      nerr++; $display("FAIL rdvalid_pulse: rdValid=%b required 0", rdValid);
    end
    $display("commit_read: done");
  endtask

  task automatic test_rollback();
    wr(9'h055); rb();
    nvec++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      nerr++; $display("FAIL rollback_count: count=%0d empty=%b required 0 1", count, empty);
    end
    rd();
    nvec++;
    if (rdValid !== 1'b0 || dataOut !== 9'h041) begin
      nerr++; $display("FAIL rollback_read: rdValid=%b dataOut=%h required 0 041", rdValid, dataOut);
    end
    wr(9'h077); cm(); rd();
    nvec++;
    if (rdValid !== 1'b1 || dataOut !== 9'h077) begin
      nerr++; $display("FAIL rollback_reuse: rdValid=%b dataOut=%h required 1 077", rdValid, dataOut);
    end
    cm(); rb();
    nvec++;
    if (count !== 5'd0 || overflow !== 1'b0) begin
      nerr++; $display("FAIL idle_ctl: count=%0d overflow=%b required 0 0", count, overflow);
    end
    $display("rollback: done");
  endtask

  task automatic test_overwrite();
    wr(9'h010); wr(9'h011); cm();
    nvec++;
    if (count !== 5'd1) begin
      nerr++; $display("FAIL overwrite_count: count=%0d required 1", count);
    end
    rd();
    nvec++;
    if (dataOut !== 9'h011 || empty !== 1'b1) begin
      nerr++; $display("FAIL overwrite_data: dataOut=%h empty=%b required 011 1", dataOut, empty);
    end
    $display("overwrite: done");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      wr(9'h0A0 + 9'(i)); cm();
    end
    wr(9'h0AF);
    nvec++;
    if (full !== 1'b1 || count !== 5'd15) begin
      nerr++; $display("FAIL full_pending: full=%b count=%0d required 1 15", full, count);
    end
    cm();
    wr(9'h1FF); rb();
    nvec++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      nerr++; $display("FAIL drop_rollback: overflow=%b count=%0d required 0 16", overflow, count);
    end
    wr(9'h1FE); cm();
    nvec++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
      nerr++; $display("FAIL full_overflow: full=%b count=%0d overflow=%b required 1 16 1", full, count, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      rd();
      nvec++;
      if (rdValid !== 1'b1 || dataOut !== 9'h0A0 + 9'(i)) begin
        nerr++; $display("FAIL full_order[%0d]: rdValid=%b dataOut=%h required 1 %h", i, rdValid, dataOut, 9'h0A0 + 9'(i));
      end
    end
    nvec++;
    if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b1) begin
      nerr++; $display("FAIL drain_flags: empty=%b full=%b overflow=%b required 1 0 1", empty, full, overflow);
    end
    $display("full: done");
  endtask

  task automatic test_parity();
    do_reset();
    wr(9'h1AA); cm();
`ifdef UART_SPEC_FIFO_PARITY_DROP_EN
    nvec++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      nerr++; $display("FAIL parity_drop: count=%0d empty=%b required 0 1", count, empty);
    end
`else
    nvec++;
    if (count !== 5'd1) begin
      nerr++; $display("FAIL parity_keep: count=%0d required 1", count);
    end
    rd();
    nvec++;
    if (rdValid !== 1'b1 || dataOut !== 9'h1AA) begin
      nerr++; $display("FAIL parity_data: rdValid=%b dataOut=%h required 1 1AA", rdValid, dataOut);
    end
`endif
    $display("parity: done");
  endtask

  task automatic test_read_commit_same();
    do_reset();
    wr(9'h033); cm(); wr(9'h034);
    readEn = 1'b1; commitWrite = 1'b1; tick(); readEn = 1'b0; commitWrite = 1'b0;
    nvec++;
    if (rdValid !== 1'b1 || dataOut !== 9'h033 || count !== 5'd1) begin
      nerr++; $display("FAIL rd_commit: rdValid=%b dataOut=%h count=%0d required 1 033 1", rdValid, dataOut, count);
    end
    rd();
    nvec++;
    if (dataOut !== 9'h034 || count !== 5'd0) begin
      nerr++; $display("FAIL rd_commit_next: dataOut=%h count=%0d required 034 0", dataOut, count);
    end
    wr(9'h035);
    readEn = 1'b1; commitWrite = 1'b1; tick(); readEn = 1'b0; commitWrite = 1'b0;
    nvec++;
    if (rdValid !== 1'b0 || count !== 5'd1 || dataOut !== 9'h034) begin
      nerr++; $display("FAIL rd_commit_empty: rdValid=%b count=%0d dataOut=%h required 0 1 034", rdValid, count, dataOut);
    end
    $display("read_commit_same: done");
  endtask

  task automatic test_ctl_and_reset();
    do_reset();
    wr(9'h066);
    commitWrite = 1'b1; rollbackWrite = 1'b1; tick(); commitWrite = 1'b0; rollbackWrite = 1'b0;
    nvec++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      nerr++; $display("FAIL commit_vs_rollback: count=%0d empty=%b required 0 1", count, empty);
    end
    wr(9'h022); cm(); wr(9'h023); rd();
    reset = 1'b0; commitWrite = 1'b1; tick(); reset = 1'b1; commitWrite = 1'b0;
    nvec++;
    if ({dataOut, rdValid, empty, full, count, overflow} !== {9'h000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
      nerr++; $display("FAIL reset_pending: dataOut=%h rdValid=%b empty=%b full=%b count=%0d overflow=%b required 000 0 1 0 0 0",
                       dataOut, rdValid, empty, full, count, overflow);
    end
    cm();
    nvec++;
    if (count !== 5'd0) begin
      nerr++; $display("FAIL post_reset_commit: count=%0d required 0", count);
    end
    $display("ctl_and_reset: done");
  endtask

  initial begin
    reset = 1'b1; dataIn = '0; writeEn = 1'b0; commitWrite = 1'b0;
    rollbackWrite = 1'b0; readEn = 1'b0;
    #2;
    test_reset();
    test_commit_read();
    test_rollback();
    test_overwrite();
    test_full();
    test_parity();
    test_read_commit_same();
    test_ctl_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_spec_fifo.md
UART_SPEC_FIFO -- requirements
Module: uart_spec_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entry count (power of two, 4..64).
REQ-002 SHALL provide parameter AW, default 4, pointer width = log2(DEPTH).
REQ-003 CLK288MHZ  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 dataIn  input  9  bit8 = parity-error flag, bits7:0 = received byte.
REQ-006 writeEn  input  1  one-cycle pulse; speculative write of dataIn.
REQ-007 commitWrite  input  1  one-cycle pulse; publish pending entry.
REQ-008 rollbackWrite  input  1  one-cycle pulse; discard pending entry.
REQ-009 readEn  input  1  pop request from consumer.
REQ-010 dataOut  output  9  popped entry, registered.
REQ-011 rdValid  output  1  one-cycle pulse; dataOut valid.
REQ-012 empty, full  output  1 each  status flags, registered.
REQ-013 count  output  AW+1  committed entry count.
REQ-014 overflow  output  1  sticky; a committed byte was lost.

Function
REQ-015 SHALL keep three pointers, each AW+1 bits with wrap bit: rdPtr, wrPtr (committed), specPtr (speculative).
REQ-016 SHALL implement pending FSM states S_IDLE, S_PEND, S_DROP.
REQ-017 S_IDLE + writeEn, occupancy (specPtr-rdPtr) < DEPTH: store dataIn at specPtr, specPtr+1, go S_PEND.
REQ-018 S_IDLE + writeEn, occupancy == DEPTH: store nothing, go S_DROP.
REQ-019 S_PEND + commitWrite: wrPtr <= specPtr, go S_IDLE; entry readable next cycle.
REQ-020 S_PEND + rollbackWrite: specPtr <= wrPtr, go S_IDLE; stored entry invisible to readers.
REQ-021 S_DROP + commitWrite: set overflow, go S_IDLE; S_DROP + rollbackWrite: go S_IDLE, overflow unchanged.
REQ-022 S_PEND + writeEn (no commit/rollback): overwrite pending slot at specPtr-1, specPtr unchanged, stay S_PEND.
REQ-023 commitWrite/rollbackWrite in S_IDLE: no effect.
REQ-024 Same-cycle commitWrite and rollbackWrite: rollback wins.
REQ-025 Same-cycle writeEn with commitWrite or rollbackWrite: commit/rollback processed, writeEn ignored.
REQ-026 readEn with count>0: dataOut <= mem[rdPtr], rdPtr+1, rdValid=1 next cycle (latency 1).
REQ-027 readEn with count==0: ignored, rdValid=0, dataOut holds.
REQ-028 Same-cycle readEn and commitWrite: pop uses pre-commit count; both take effect.
REQ-029 count = wrPtr-rdPtr; empty = (count==0); full = (specPtr-rdPtr == DEPTH); all updated one cycle after the causing event.
REQ-030 Pointer arithmetic SHALL wrap modulo 2*DEPTH; no pointer saturates.

Reset
REQ-031 reset==0 at rising edge: rdPtr=wrPtr=specPtr=0, state S_IDLE, dataOut=0, rdValid=0, empty=1, full=0, count=0, overflow=0.
REQ-032 Reset mid-pending SHALL discard pending entry; reset dominates all inputs that cycle.
REQ-033 Memory array SHALL NOT be reset.

Configuration
REQ-034 Macro UART_SPEC_FIFO_PARITY_DROP_EN defined: commitWrite in S_PEND with stored bit8==1 SHALL act as rollback; no parity-flagged entry ever becomes readable.
REQ-035 Macro undefined: bit8 stored and returned unaltered; commit behaves per REQ-019.

Verification
REQ-036 writeEn dataIn=0x041, commitWrite 2 cycles later, readEn -> rdValid next cycle, dataOut=0x041, count 1->0, empty=1.
REQ-037 writeEn 0x055, rollbackWrite -> count stays 0, empty=1, readEn gives no rdValid; next write lands in same slot.
REQ-038 16 committed writes, 17th writeEn+commitWrite -> full=1, count=16, overflow=1; 16 reads return original order.
REQ-039 writeEn 0x1AA, commitWrite -> with macro: count=0; without: count=1, dataOut=0x1AA.
REQ-040 writeEn, then commitWrite+rollbackWrite same cycle -> rollback wins, count=0; reset=0 during S_PEND -> all outputs at reset values.
